// File: rtl/psw_register.sv
// NZVC processor status word with J/K flag update, branch condition decode and
// an optional save/restore shadow stack (built when PSW_SHADOW_STACK_EN is defined).
module psw_register #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       J_N,
  input  logic       K_N,
  input  logic       J_Z,
  input  logic       K_Z,
  input  logic       J_V,
  input  logic       K_V,
  input  logic       J_C,
  input  logic       K_C,
  input  logic       psw_ce,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] cond,
  output logic [3:0] psw_out,
  output logic       branch_taken,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam int unsigned PSW_W = 4;

  logic [PSW_W-1:0] psw_q, psw_d;
  logic [PSW_W-1:0] jk_c;
  logic [PSW_W-1:0] j_c, k_c;
  logic [PSW_W-1:0] pop_data_c;
  logic             do_pop_c;

  assign j_c = {J_N, J_Z, J_V, J_C};
  assign k_c = {K_N, K_Z, K_V, K_C};

  // Per-flag JK: 00 hold, 10 set, 01 clear, 11 toggle
  always_comb begin
    jk_c = psw_q;
    for (int i = 0; i < int'(PSW_W); i++) begin
      case ({j_c[i], k_c[i]})
        2'b10:   jk_c[i] = 1'b1;
        2'b01:   jk_c[i] = 1'b0;
        2'b11:   jk_c[i] = ~psw_q[i];
        default: jk_c[i] = psw_q[i];
      endcase
    end
  end

  // Next PSW: restore from stack beats direct load beats JK update
  always_comb begin
    psw_d = psw_q;
    if (do_pop_c) begin
      psw_d = pop_data_c;
    end else if (wr_en) begin
      psw_d = wr_data;
    end else if (psw_ce) begin
      psw_d = jk_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psw_q <= '0;
    end else begin
      psw_q <= psw_d;
    end
  end

  assign psw_out = psw_q;

  // Branch condition decode straight off the held flags
  always_comb begin
    logic n, z, v, c, x;
    n = psw_q[3];
    z = psw_q[2];
    v = psw_q[1];
    c = psw_q[0];
    x = n ^ v;
    branch_taken = 1'b0;
    case (cond)
      4'h0: branch_taken = 1'b1;
      4'h1: branch_taken = z;
      4'h2: branch_taken = ~z;
      4'h3: branch_taken = n;
      4'h4: branch_taken = ~n;
      4'h5: branch_taken = c;
      4'h6: branch_taken = ~c;
      4'h7: branch_taken = v;
      4'h8: branch_taken = ~v;
      4'h9: branch_taken = x;
      4'hA: branch_taken = ~x;
      4'hB: branch_taken = z | x;
      4'hC: branch_taken = ~(z | x);
      4'hD: branch_taken = ~c & ~z;
      4'hE: branch_taken = c | z;
      default: branch_taken = 1'b0;
    endcase
  end

`ifdef PSW_SHADOW_STACK_EN
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PSW_W-1:0] stack_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             full_c, empty_c, do_push_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  // Simultaneous push/pop, push when full and pop when empty are all errors
  always_comb begin
    count_d   = count_q;
    err_d     = 1'b0;
    do_push_c = 1'b0;
    do_pop_c  = 1'b0;
    if (push && pop) begin
      err_d = 1'b1;
    end else if (push) begin
      if (full_c) begin
        err_d = 1'b1;
      end else begin
        do_push_c = 1'b1;
        count_d   = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty_c) begin
        err_d = 1'b1;
      end else begin
        do_pop_c = 1'b1;
        count_d  = count_q - CNT_W'(1);
      end
    end
  end

  assign pop_data_c = stack_q[ADDR_W'(count_q - CNT_W'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      stack_q[ADDR_W'(count_q)] <= psw_q;
    end
  end

  assign stack_full  = full_c;
  assign stack_empty = empty_c;
  assign stack_err   = err_q;
`else
  logic unused_stack_ops;

  assign unused_stack_ops = push ^ pop ^ (DEPTH == 0);
  assign do_pop_c         = 1'b0;
  assign pop_data_c       = '0;
  assign stack_full       = 1'b0;
  assign stack_empty      = 1'b1;
  assign stack_err        = 1'b0;
`endif

endmodule

// File: tb/tb_psw_register.sv
// Randomized self-checking bench for psw_register against a queue-based PSW model.
module tb_psw_register;

  localparam int unsigned DEPTH = 4;
`ifdef PSW_SHADOW_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] j, k;
  logic       psw_ce, wr_en, push, pop;
  logic [3:0] wr_data, cond;
  logic [3:0] psw_out;
  logic       branch_taken, stack_full, stack_empty, stack_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] m_psw;
  logic [3:0] m_stack[$];
  logic       m_err;

  always #5 clk = ~clk;

  psw_register #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .J_N(j[3]), .K_N(k[3]), .J_Z(j[2]), .K_Z(k[2]),
    .J_V(j[1]), .K_V(k[1]), .J_C(j[0]), .K_C(k[0]),
    .psw_ce(psw_ce), .wr_en(wr_en), .wr_data(wr_data),
    .push(push), .pop(pop), .cond(cond),
    .psw_out(psw_out), .branch_taken(branch_taken),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_branch(input logic [3:0] p, input logic [3:0] c);
    logic n, z, v, cy;
    logic [15:0] tbl;
    {n, z, v, cy} = p;
    // Bit i of tbl is the outcome of condition code i
    tbl = {1'b0, cy | z, ~cy & ~z, ~(z | (n ^ v)), z | (n ^ v), ~(n ^ v), n ^ v, ~v,
           v, ~cy, cy, ~n, n, ~z, z, 1'b1};
    return tbl[c];
  endfunction

  function automatic void model_reset();
    m_psw = 4'b0000;
    m_stack.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_clock();
    logic       restore;
    logic [3:0] rdata;
    restore = 1'b0;
    rdata   = 4'b0000;
    m_err   = 1'b0;
    if (STACK_EN) begin
      if (push && pop) m_err = 1'b1;
      else if (push) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_psw);
      end else if (pop) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else begin
          restore = 1'b1;
          rdata   = m_stack.pop_back();
        end
      end
    end
    if (restore) m_psw = rdata;
    else if (wr_en) m_psw = wr_data;
    else if (psw_ce) begin
      for (int i = 0; i < 4; i++) begin
        if (j[i] && k[i]) m_psw[i] = ~m_psw[i];
        else if (j[i]) m_psw[i] = 1'b1;
        else if (k[i]) m_psw[i] = 1'b0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".psw"},   8'(psw_out), 8'(m_psw));
    check({tag, ".br"},    8'(branch_taken), 8'(model_branch(m_psw, cond)));
    check({tag, ".full"},  8'(stack_full), 8'(STACK_EN && m_stack.size() == DEPTH));
    check({tag, ".empty"}, 8'(stack_empty), 8'(m_stack.size() == 0));
    check({tag, ".err"},   8'(stack_err), 8'(m_err));
  endtask

  task automatic idle();
    j = '0; k = '0; psw_ce = 1'b0; wr_en = 1'b0; wr_data = '0;
    push = 1'b0; pop = 1'b0;
  endtask

  // One clock: model and DUT both advance, outputs compared 1ns after the edge
  task automatic cycle(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
  endtask

  task automatic load(input logic [3:0] v);
    idle(); wr_en = 1'b1; wr_data = v;
    cycle("load");
    idle();
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".psw"}, 8'(psw_out), 8'h00);
    check({tag, ".empty"}, 8'(stack_empty), 8'h01);
    check({tag, ".err"}, 8'(stack_err), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    cond  = 4'h0;
    rst_n = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // JK set N and toggle C, then toggle C back
    psw_ce = 1'b1; j = 4'b1001; k = 4'b0001;
    cycle("jk1");
    check("jk1.const", 8'(psw_out), 8'h09);
    j = 4'b0001; k = 4'b0001;
    cycle("jk2");
    check("jk2.const", 8'(psw_out), 8'h08);

    // Direct load beats a concurrent JK clear
    load(4'b0000);
    psw_ce = 1'b1; k = 4'b0100; wr_en = 1'b1; wr_data = 4'b0110;
    cycle("wrwin");
    check("wrwin.const", 8'(psw_out), 8'h06);
    idle();

    // Branch decode boundaries
    load(4'b1000);
    cond = 4'h9; #1 check("cond9", 8'(branch_taken), 8'h01);
    cond = 4'hA; #1 check("condA", 8'(branch_taken), 8'h00);
    cond = 4'hB; #1 check("condB", 8'(branch_taken), 8'h01);
    load(4'b0101);
    cond = 4'hD; #1 check("condD", 8'(branch_taken), 8'h00);
    cond = 4'hE; #1 check("condE", 8'(branch_taken), 8'h01);
    cond = 4'h0; #1 check("cond0", 8'(branch_taken), 8'h01);
    cond = 4'hF; #1 check("condF", 8'(branch_taken), 8'h00);
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1 check("condsweep", 8'(branch_taken), 8'(model_branch(m_psw, cond)));
    end

    // Save, overwrite, restore
    load(4'b1010);
    push = 1'b1; cycle("push1"); idle();
    load(4'b0001);
    pop = 1'b1; cycle("pop1"); idle();
    check("restore.const", 8'(psw_out), STACK_EN ? 8'h0A : 8'h01);
    check("restore.empty", 8'(stack_empty), 8'h01);

    // Overflow: five pushes, error pulse lasts one cycle
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; psw_ce = 1'b1; j = 4'(i); k = 4'(~i);
      cycle("fill");
      if (i == 3) check("full4", 8'(stack_full), 8'(STACK_EN));
    end
    check("ovf.err", 8'(stack_err), 8'(STACK_EN));
    idle();
    cycle("ovf.clear");
    check("ovf.errclr", 8'(stack_err), 8'h00);
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1; cycle("drain");
    end
    pop = 1'b1; cycle("udf");
    check("udf.err", 8'(stack_err), 8'(STACK_EN));
    idle();

    // Reset in the middle of a push with two entries held
    push = 1'b1; cycle("pre2a"); cycle("pre2b");
    @(posedge clk); #2;
    async_reset("midrst");
    idle();
    cycle("postrst");

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      j       = 4'($urandom);
      k       = 4'($urandom);
      psw_ce  = ($urandom_range(3) != 0);
      wr_en   = ($urandom_range(7) == 0);
      wr_data = 4'($urandom);
      push    = ($urandom_range(3) == 0);
      pop     = ($urandom_range(3) == 0);
      cond    = 4'($urandom);
      if ($urandom_range(499) == 0) begin
        async_reset("rndrst");
      end else begin
        cycle("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
